cop_seq: RTL

- Sequencer between the single-cycle RV32 core and the 8-bit GCD/LCM coprocessor.
- Accepts a decoded coprocessor instruction from the core and stalls fetch/PC while the coprocessor runs.
- Issues operands to the coprocessor over a req/ack handshake, then waits for done.
- Produces a one-cycle register-file writeback of the zero-extended result, with a timeout guard against a hung coprocessor.

---
 rtl/cop_seq_if.sv | 52 +++++
 rtl/cop_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cop_seq_if.sv
// rtl/cop_seq_if.sv - operand/result handshake bundle between sequencer and GCD/LCM coprocessor
//
// Purpose:
//   Groups the coprocessor-side handshake so the sequencer and the
//   coprocessor (or a testbench standing in for it) share one port.
//
// Signals:
//   cop_req   sequencer -> cop  operands valid
//   cop_op    sequencer -> cop  0 = GCD, 1 = LCM
//   cop_a     sequencer -> cop  operand A
//   cop_b     sequencer -> cop  operand B
//   cop_ack   cop -> sequencer  operands accepted
//   cop_done  cop -> sequencer  result valid, single-cycle pulse
//   cop_res   cop -> sequencer  result
//
// Modports:
//   master  sequencer side
//   slave   coprocessor side

interface cop_seq_if #(
  parameter int DATA_W = 8
) ();

  logic              cop_req;
  logic              cop_op;
  logic [DATA_W-1:0] cop_a;
  logic [DATA_W-1:0] cop_b;
  logic              cop_ack;
  logic              cop_done;
  logic [DATA_W-1:0] cop_res;

  modport master (
    output cop_req,
    output cop_op,
    output cop_a,
    output cop_b,
    input  cop_ack,
    input  cop_done,
    input  cop_res
  );

  modport slave (
    input  cop_req,
    input  cop_op,
    input  cop_a,
    input  cop_b,
    output cop_ack,
    output cop_done,
    output cop_res
  );

endinterface

// File: rtl/cop_seq.sv
// rtl/cop_seq.sv - RV32 core to GCD/LCM coprocessor sequencer with stall, writeback and timeout
//
// Purpose:
//   Accepts a decoded coprocessor instruction, stalls the core while the
//   coprocessor runs, issues operands over a req/ack handshake, waits for
//   done and performs a one-cycle zero-extended register-file writeback.
//   A cycle counter aborts the operation (err, wb_data = 0) if the
//   coprocessor spends TIMEOUT_CYC cycles in ISSUE+WAIT without finishing.
//
// Optional feature (macro ZERO_BYPASS_EN):
//   When defined, a start with a zero operand skips the coprocessor and
//   writes back directly one cycle later (GCD -> the other operand,
//   LCM -> 0). When undefined, zero operands go through the coprocessor.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   coprocessor instruction in decode (held until core advances)
//   op       in   0 = GCD, 1 = LCM
//   opa/opb  in   operands
//   rd_in    in   destination register index
//   cop      if   coprocessor handshake (master modport)
//   stall    out  hold PC/instruction (combinational)
//   wb_en    out  register-file write strobe, one cycle
//   wb_rd    out  write index (latched rd)
//   wb_data  out  zero-extended result, holds until next capture
//   busy     out  sequencer not in IDLE
//   err      out  sticky timeout flag, cleared by the next accepted start

module cop_seq #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic [4:0]        rd_in,
  cop_seq_if.master         cop,
  output logic              stall,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  // cnt_q holds the number of ISSUE/WAIT cycles already completed, so
  // cnt_inc is the count including the current cycle; expiry fires in the
  // TIMEOUT_CYC-th cycle spent in ISSUE+WAIT.
  logic [TO_W-1:0]   cnt_inc;
  logic              expire;

`ifdef ZERO_BYPASS_EN
  logic              zero_opnd;
  logic [DATA_W-1:0] bypass_res;
`endif

  assign cnt_inc = cnt_q + TO_W'(1);
  assign expire  = (cnt_inc == TO_W'(TIMEOUT_CYC));

`ifdef ZERO_BYPASS_EN
  assign zero_opnd  = (opa == '0) || (opb == '0);
  // gcd(x,0) = x (and 0 when both are zero); lcm with a zero operand is 0.
  assign bypass_res = op ? '0 : ((opa == '0) ? opb : opa);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wb_en_d = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The core must not advance past the instruction in the very cycle
        // it is decoded, hence the combinational stall.
        stall = start;
        if (start) begin
          op_d  = op;
          a_d   = opa;
          b_d   = opb;
          rd_d  = rd_in;
          err_d = 1'b0;
          cnt_d = '0;
`ifdef ZERO_BYPASS_EN
          if (zero_opnd) begin
            data_d  = 32'(bypass_res);
            wb_en_d = 1'b1;
            state_d = S_WB;
          end else begin
            req_d   = 1'b1;
            state_d = S_ISSUE;
          end
`else
          req_d   = 1'b1;
          state_d = S_ISSUE;
`endif
        end
      end

      S_ISSUE: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (cop.cop_ack && cop.cop_done) begin
          data_d  = 32'(cop.cop_res);
          req_d   = 1'b0;
          wb_en_d = 1'b1;
          state_d = S_WB;
        end else if (expire) begin
          err_d   = 1'b1;
          data_d  = '0;
          req_d   = 1'b0;
          wb_en_d = 1'b1;
          state_d = S_WB;
        end else if (cop.cop_ack) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        // done has priority over a timeout expiring in the same cycle.
        if (cop.cop_done) begin
          data_d  = 32'(cop.cop_res);
          wb_en_d = 1'b1;
          state_d = S_WB;
        end else if (expire) begin
          err_d   = 1'b1;
          data_d  = '0;
          wb_en_d = 1'b1;
          state_d = S_WB;
        end
      end

      S_WB: begin
        // start is still high here but belongs to the instruction being
        // retired; it is not a new request.
        stall   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wb_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wb_en_q <= wb_en_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign cop.cop_req = req_q;
  assign cop.cop_op  = op_q;
  assign cop.cop_a   = a_q;
  assign cop.cop_b   = b_q;
  assign wb_en       = wb_en_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule
